// File: rtl/buffer_write_arbiter.sv
// Credit-aware round-robin arbiter merging NUM_REQ producers onto the write port
// of a credit-based CDC buffer; bursts of up to QUANTUM beats per grant.
//
// state | meaning
// IDLE  | no owner; round-robin pick from rr_ptr, transfer immediately if credit allows
// BURST | owner locked; only owner may transfer until QUANTUM beats or owner drops valid
module buffer_write_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 1024,
   parameter int ADDR_W  = $clog2(DEPTH),
   parameter int QUANTUM = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                     re_clk,
   input  logic                     re_reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [ADDR_W:0]          re_credit,
   output logic                     re_valid,
   output logic [WIDTH-1:0]         re_data,
   output logic [IDX_W-1:0]         grant_id,
   output logic                     credit_stall
);

   localparam int CNT_W = $clog2(QUANTUM + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic               re_valid_q, re_valid_d;
   logic [WIDTH-1:0]   re_data_q, re_data_d;
   logic [IDX_W-1:0]   grant_id_q, grant_id_d;

   logic [ADDR_W:0]    eff_credit;
   logic               can_issue;
   logic               xfer;
   logic [IDX_W-1:0]   sel_idx;
   logic [IDX_W-1:0]   pick;
   logic               pick_found;
   logic [CNT_W-1:0]   beat_nxt;
   int                 scan_j;

   function automatic logic [IDX_W-1:0] nxt_idx(input logic [IDX_W-1:0] i);
      return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
   endfunction

   // The beat currently on re_valid is not yet reflected in re_credit.
   assign eff_credit   = re_credit - {{ADDR_W{1'b0}}, re_valid_q};
   assign can_issue    = (eff_credit != '0);
   assign credit_stall = !re_reset && (|req_valid) && !can_issue;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      req_ready  = '0;
      xfer       = 1'b0;
      sel_idx    = owner_q;
      pick       = '0;
      pick_found = 1'b0;
      scan_j     = 0;
      beat_nxt   = beat_cnt_q + CNT_W'(1);

      for (int k = 0; k < NUM_REQ; k++) begin
         scan_j = int'(rr_ptr_q) + k;
         if (scan_j >= NUM_REQ) scan_j = scan_j - NUM_REQ;
         if (!pick_found && req_valid[scan_j]) begin
            pick       = IDX_W'(scan_j);
            pick_found = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (pick_found && can_issue) begin
               xfer       = 1'b1;
               sel_idx    = pick;
               beat_cnt_d = CNT_W'(1);
               if (QUANTUM == 1) begin
                  rr_ptr_d = nxt_idx(pick);
               end else begin
                  state_d = BURST;
                  owner_d = pick;
               end
            end
         end
         BURST: begin
            if (req_valid[owner_q]) begin
               if (can_issue) begin
                  xfer       = 1'b1;
                  beat_cnt_d = beat_nxt;
                  if (beat_nxt == CNT_W'(QUANTUM)) begin
                     state_d  = IDLE;
                     rr_ptr_d = nxt_idx(owner_q);
                  end
               end
            end else begin
               // Owner dropped: release with one bubble, nobody else served this cycle.
               state_d  = IDLE;
               rr_ptr_d = nxt_idx(owner_q);
            end
         end
         default: state_d = IDLE;
      endcase

      if (re_reset) xfer = 1'b0;
      if (xfer) req_ready[sel_idx] = 1'b1;

      re_valid_d = xfer;
      re_data_d  = xfer ? req_data[sel_idx*WIDTH +: WIDTH] : re_data_q;
      grant_id_d = xfer ? sel_idx : grant_id_q;
   end

   always_ff @(posedge re_clk) begin
      if (re_reset) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         beat_cnt_q <= '0;
         re_valid_q <= 1'b0;
         re_data_q  <= '0;
         grant_id_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
         re_valid_q <= re_valid_d;
         re_data_q  <= re_data_d;
         grant_id_q <= grant_id_d;
      end
   end

   assign re_valid = re_valid_q;
   assign re_data  = re_data_q;
   assign grant_id = grant_id_q;

endmodule
